// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg
// Shared definitions for the 8-bit RISC control path: opcodes, ALU operation
// encodings (also consumed by the ALU), FSM state encoding and instruction
// field bit positions.
// Build option: STEP_DEBUG_EN adds the PAUSE state used for single-stepping.
package risc_ctrl_pkg;

    localparam int INSTR_W   = 16;
    localparam int IMM_W     = 8;
    localparam int REG_SEL_W = 3;
    localparam int ALU_OP_W  = 3;

    // Instruction field positions: op | rd | rs1 | rs2 | xxx, imm overlays [7:0]
    localparam int FLD_OP_MSB  = 15;
    localparam int FLD_OP_LSB  = 12;
    localparam int FLD_RD_MSB  = 11;
    localparam int FLD_RD_LSB  = 9;
    localparam int FLD_RS1_MSB = 8;
    localparam int FLD_RS1_LSB = 6;
    localparam int FLD_RS2_MSB = 5;
    localparam int FLD_RS2_LSB = 3;
    localparam int FLD_IMM_MSB = 7;
    localparam int FLD_IMM_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation encodings
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'b100;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
`ifdef STEP_DEBUG_EN
        ,
        ST_PAUSE     = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/risc_ctrl_decode.sv
// risc_ctrl_decode
// Combinational instruction decoder: IR -> register selects, ALU op,
// writeback source and instruction class flags.
// Ports:
//   ir             in   instruction register
//   dest_sel       out  rd field
//   src1_sel       out  rs1 field
//   src2_sel       out  rs2 field (forced to 0 for NOT)
//   alu_op         out  ALU operation (ADD for non-ALU instructions)
//   immediate      out  imm field
//   load_immediate out  LDI: writeback takes the immediate
//   is_alu         out  ADD/SUB/AND/OR/NOT
//   is_jmp         out  JMP
//   is_halt        out  HALT
//   is_illegal     out  undefined opcode (executes as NOP)
module risc_ctrl_decode
    import risc_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0]   ir,
    output logic [REG_SEL_W-1:0] dest_sel,
    output logic [REG_SEL_W-1:0] src1_sel,
    output logic [REG_SEL_W-1:0] src2_sel,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [IMM_W-1:0]     immediate,
    output logic                 load_immediate,
    output logic                 is_alu,
    output logic                 is_jmp,
    output logic                 is_halt,
    output logic                 is_illegal
);

    logic [3:0] opcode;

    assign opcode    = ir[FLD_OP_MSB:FLD_OP_LSB];
    assign dest_sel  = ir[FLD_RD_MSB:FLD_RD_LSB];
    assign src1_sel  = ir[FLD_RS1_MSB:FLD_RS1_LSB];
    assign immediate = ir[FLD_IMM_MSB:FLD_IMM_LSB];

    always_comb begin
        src2_sel       = ir[FLD_RS2_MSB:FLD_RS2_LSB];
        alu_op         = ALU_ADD;
        load_immediate = 1'b0;
        is_alu         = 1'b0;
        is_jmp         = 1'b0;
        is_halt        = 1'b0;
        is_illegal     = 1'b0;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_NOT: begin
                // NOT is unary; keep the second read port parked on r0
                is_alu   = 1'b1;
                alu_op   = ALU_NOT;
                src2_sel = '0;
            end
            OP_LDI:  load_immediate = 1'b1;
            OP_JMP:  is_jmp = 1'b1;
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer
// Multi-cycle control FSM for the 8-bit RISC datapath. Owns PC and IR,
// fetches from instruction memory and drives the register-file/ALU controls.
// Build option: STEP_DEBUG_EN adds the step input and a PAUSE state entered
// instead of FETCH after each instruction; a step pulse resumes for one.
//
// Fetch handshake: imem_req is held high for the whole FETCH state with
// imem_addr = PC; the first cycle in which imem_ack is high transfers
// imem_rdata into IR. imem_ack in any other state is ignored.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   start                    pulse: leave IDLE and fetch from current PC
//   step                     (STEP_DEBUG_EN) pulse: leave PAUSE
//   imem_req/addr/ack/rdata  instruction fetch interface
//   current_instruction      IR
//   program_counter_out      PC
//   alu_op, *_reg_sel        datapath controls decoded from IR
//   immediate_data           IR[7:0]
//   load_immediate           writeback source is immediate_data
//   reg_write_enable         one-cycle register write strobe in WRITEBACK
//   busy, halted             status
//   illegal_op               sticky undefined-opcode flag
//   state_dbg                current FSM state encoding
module risc_sequencer
    import risc_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16   // fixed by the instruction format
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef STEP_DEBUG_EN
    input  logic                   step,
`endif
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic [PC_WIDTH-1:0]    program_counter_out,
    output logic [2:0]             alu_op,
    output logic [2:0]             dest_reg_sel,
    output logic [2:0]             src_reg1_sel,
    output logic [2:0]             src_reg2_sel,
    output logic [7:0]             immediate_data,
    output logic                   load_immediate,
    output logic                   reg_write_enable,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal_op,
    output logic [2:0]             state_dbg
);

`ifdef STEP_DEBUG_EN
    localparam state_t ST_REFETCH = ST_PAUSE;
`else
    localparam state_t ST_REFETCH = ST_FETCH;
`endif

    state_t                   state;
    state_t                   state_next;
    logic                     busy_next;
    logic [PC_WIDTH-1:0]      pc;
    logic [INSTR_WIDTH-1:0]   ir;

    logic                     is_alu;
    logic                     is_jmp;
    logic                     is_halt;
    logic                     is_illegal;

    risc_ctrl_decode u_decode (
        .ir             (ir),
        .dest_sel       (dest_reg_sel),
        .src1_sel       (src_reg1_sel),
        .src2_sel       (src_reg2_sel),
        .alu_op         (alu_op),
        .immediate      (immediate_data),
        .load_immediate (load_immediate),
        .is_alu         (is_alu),
        .is_jmp         (is_jmp),
        .is_halt        (is_halt),
        .is_illegal     (is_illegal)
    );

    assign imem_addr           = pc;
    assign program_counter_out = pc;
    assign current_instruction = ir;
    assign state_dbg           = state;

    // Next-state logic; the registered status outputs are derived from it so
    // they change on the same edge as the state itself.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start) state_next = ST_FETCH;
            ST_FETCH:     if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_alu)              state_next = ST_EXECUTE;
                else if (load_immediate) state_next = ST_WRITEBACK;
                else if (is_halt)        state_next = ST_HALT;
                else                     state_next = ST_REFETCH; // JMP, NOP, illegal
            end
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_REFETCH;
            ST_HALT:      state_next = ST_HALT;
`ifdef STEP_DEBUG_EN
            ST_PAUSE:     if (step) state_next = ST_FETCH;
`endif
            default:      state_next = ST_IDLE;
        endcase

        busy_next = 1'b1;
        if (state_next == ST_IDLE || state_next == ST_HALT) busy_next = 1'b0;
`ifdef STEP_DEBUG_EN
        if (state_next == ST_PAUSE) busy_next = 1'b0;
`endif
    end

    // Asynchronous reset clears the strobes at once, so a write or fetch in
    // flight is abandoned without a partial register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            pc               <= '0;
            ir               <= '0;
            illegal_op       <= 1'b0;
            imem_req         <= 1'b0;
            reg_write_enable <= 1'b0;
            busy             <= 1'b0;
            halted           <= 1'b0;
        end else begin
            state            <= state_next;
            imem_req         <= (state_next == ST_FETCH);
            reg_write_enable <= (state_next == ST_WRITEBACK);
            halted           <= (state_next == ST_HALT);
            busy             <= busy_next;
            case (state)
                ST_FETCH: begin
                    if (imem_ack) ir <= imem_rdata;
                end
                ST_DECODE: begin
                    if (is_jmp)
                        pc <= PC_WIDTH'(immediate_data);
                    else if (!is_alu && !load_immediate && !is_halt)
                        pc <= pc + PC_WIDTH'(1);   // NOP / illegal
                    if (is_illegal) illegal_op <= 1'b1;
                end
                ST_WRITEBACK: pc <= pc + PC_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer
// Directed bench for risc_sequencer: a behavioural instruction memory with a
// programmable ack delay, a negedge monitor that logs fetches and register
// writes, and one task per scenario. Define STEP_DEBUG_EN to also exercise
// single-stepping.
module tb_risc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
`ifdef STEP_DEBUG_EN
    logic        step = 1'b0;
`endif
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] current_instruction;
    logic [7:0]  pc_out;
    logic [2:0]  alu_op, dest_sel, src1_sel, src2_sel;
    logic [7:0]  imm;
    logic        ldi, rwe, busy, halted, illegal_op;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_mis = 0;

    risc_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
`ifdef STEP_DEBUG_EN
        .step                (step),
`endif
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ack            (imem_ack),
        .imem_rdata          (imem_rdata),
        .current_instruction (current_instruction),
        .program_counter_out (pc_out),
        .alu_op              (alu_op),
        .dest_reg_sel        (dest_sel),
        .src_reg1_sel        (src1_sel),
        .src_reg2_sel        (src2_sel),
        .immediate_data      (imm),
        .load_immediate      (ldi),
        .reg_write_enable    (rwe),
        .busy                (busy),
        .halted              (halted),
        .illegal_op          (illegal_op),
        .state_dbg           (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    logic [15:0] mem [0:255];
    int          ack_delay = 0;
    logic        ack_spurious = 1'b0;
    int          wait_cnt = 0;

    assign imem_ack   = imem_req ? (wait_cnt >= ack_delay) : ack_spurious;
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         fetch_cyc[$];
    logic [7:0] fetch_addr[$];
    int         fetch_wait[$];
    int         run = 0;
    int         addr_glitch = 0;
    logic [7:0] req_addr = 8'h00;
    int         wb_cyc[$];
    logic [2:0] wb_dest[$], wb_src1[$], wb_src2[$], wb_alu[$];
    logic       wb_ldi[$];
    logic [7:0] wb_imm[$], wb_pc[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_req) begin
            if (run > 0 && imem_addr !== req_addr) addr_glitch = addr_glitch + 1;
            req_addr = imem_addr;
            if (imem_ack) begin
                fetch_cyc.push_back(cyc);
                fetch_addr.push_back(imem_addr);
                fetch_wait.push_back(run);
                run = 0;
            end else begin
                run = run + 1;
            end
        end else begin
            run = 0;
        end
        if (rwe) begin
            wb_cyc.push_back(cyc);
            wb_dest.push_back(dest_sel);
            wb_src1.push_back(src1_sel);
            wb_src2.push_back(src2_sel);
            wb_alu.push_back(alu_op);
            wb_ldi.push_back(ldi);
            wb_imm.push_back(imm);
            wb_pc.push_back(pc_out);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        fetch_cyc.delete(); fetch_addr.delete(); fetch_wait.delete();
        wb_cyc.delete(); wb_dest.delete(); wb_src1.delete(); wb_src2.delete();
        wb_alu.delete(); wb_ldi.delete(); wb_imm.delete(); wb_pc.delete();
        run = 0;
        addr_glitch = 0;
    endtask

    task automatic fill_halts();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        ack_spurious = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_fetches(input int n, input string tag);
        int budget;
        budget = 300;
        while (fetch_cyc.size() < n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        if (fetch_cyc.size() < n) begin
            n_mis++;
            $display("FAIL %s_timeout: fetches got %0d want %0d", tag, fetch_cyc.size(), n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_mis++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
        n_cmp++; if (current_instruction !== 16'h0000) begin n_mis++; $display("FAIL rst_ir: got %h want 0000", current_instruction); end
        n_cmp++; if (pc_out !== 8'h00) begin n_mis++; $display("FAIL rst_pc: got %h want 00", pc_out); end
        n_cmp++; if ({alu_op, dest_sel, src1_sel, src2_sel} !== 12'h000) begin n_mis++; $display("FAIL rst_ctl: got %h want 000", {alu_op, dest_sel, src1_sel, src2_sel}); end
        n_cmp++; if ({imm, ldi, rwe} !== 10'h000) begin n_mis++; $display("FAIL rst_wb: got %h want 000", {imm, ldi, rwe}); end
        n_cmp++; if ({busy, halted, illegal_op} !== 3'b000) begin n_mis++; $display("FAIL rst_status: got %b want 000", {busy, halted, illegal_op}); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_mis++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        clear_log();
        // No start: stays idle
        run_cycles(5);
        n_cmp++; if (fetch_cyc.size() !== 0) begin n_mis++; $display("FAIL idle_no_fetch: got %0d want 0", fetch_cyc.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_ldi();
        fill_halts();
        mem[0] = 16'h50AA;
        mem[1] = 16'h520C;
        do_reset();
        pulse_start();
        wait_fetches(3, "ldi");
        n_cmp++; if (wb_cyc.size() !== 2) begin n_mis++; $display("FAIL ldi_wr_count: got %0d want 2", wb_cyc.size()); end
        if (wb_cyc.size() >= 2 && fetch_cyc.size() >= 3) begin
            n_cmp++; if ({wb_dest[0], wb_imm[0], wb_ldi[0]} !== {3'd0, 8'hAA, 1'b1}) begin n_mis++; $display("FAIL ldi0_fields: got %h want %h", {wb_dest[0], wb_imm[0], wb_ldi[0]}, {3'd0, 8'hAA, 1'b1}); end
            n_cmp++; if ({wb_dest[1], wb_imm[1], wb_ldi[1]} !== {3'd1, 8'h0C, 1'b1}) begin n_mis++; $display("FAIL ldi1_fields: got %h want %h", {wb_dest[1], wb_imm[1], wb_ldi[1]}, {3'd1, 8'h0C, 1'b1}); end
            n_cmp++; if (fetch_cyc[1] - fetch_cyc[0] !== 3) begin n_mis++; $display("FAIL ldi0_cpi: got %0d want 3", fetch_cyc[1] - fetch_cyc[0]); end
            n_cmp++; if (fetch_cyc[2] - fetch_cyc[1] !== 3) begin n_mis++; $display("FAIL ldi1_cpi: got %0d want 3", fetch_cyc[2] - fetch_cyc[1]); end
            n_cmp++; if (fetch_addr[2] !== 8'h02) begin n_mis++; $display("FAIL ldi_pc2: got %h want 02", fetch_addr[2]); end
            n_cmp++; if (wb_cyc[0] - fetch_cyc[0] !== 2) begin n_mis++; $display("FAIL ldi_wb_lat: got %0d want 2", wb_cyc[0] - fetch_cyc[0]); end
        end
    endtask

    task automatic test_alu();
        logic [2:0] exp_alu[5];
        logic [2:0] exp_src2[5];
        exp_alu  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        exp_src2 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        fill_halts();
        mem[0] = 16'h0008;  // ADD r0,r0,r1
        mem[1] = 16'h1008;  // SUB
        mem[2] = 16'h2008;  // AND
        mem[3] = 16'h3008;  // OR
        mem[4] = 16'h4008;  // NOT r0,r0 with a stray rs2 field
        do_reset();
        ack_spurious = 1'b1;  // ack outside FETCH must be ignored
        pulse_start();
        wait_fetches(6, "alu");
        n_cmp++; if (wb_cyc.size() !== 5) begin n_mis++; $display("FAIL alu_wr_count: got %0d want 5", wb_cyc.size()); end
        if (wb_cyc.size() >= 5 && fetch_cyc.size() >= 6) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (wb_alu[i] !== exp_alu[i]) begin n_mis++; $display("FAIL alu%0d_op: got %b want %b", i, wb_alu[i], exp_alu[i]); end
                n_cmp++; if ({wb_dest[i], wb_src1[i], wb_src2[i]} !== {3'd0, 3'd0, exp_src2[i]}) begin n_mis++; $display("FAIL alu%0d_sel: got %h want %h", i, {wb_dest[i], wb_src1[i], wb_src2[i]}, {3'd0, 3'd0, exp_src2[i]}); end
                n_cmp++; if (wb_ldi[i] !== 1'b0) begin n_mis++; $display("FAIL alu%0d_ldi: got %b want 0", i, wb_ldi[i]); end
                n_cmp++; if (wb_pc[i] !== 8'(i)) begin n_mis++; $display("FAIL alu%0d_pc: got %h want %h", i, wb_pc[i], 8'(i)); end
                n_cmp++; if (fetch_cyc[i+1] - fetch_cyc[i] !== 4) begin n_mis++; $display("FAIL alu%0d_cpi: got %0d want 4", i, fetch_cyc[i+1] - fetch_cyc[i]); end
                n_cmp++; if (wb_cyc[i] - fetch_cyc[i] !== 3) begin n_mis++; $display("FAIL alu%0d_wb_lat: got %0d want 3", i, wb_cyc[i] - fetch_cyc[i]); end
            end
        end
        ack_spurious = 1'b0;
    endtask

    task automatic test_wait_wrap();
        fill_halts();
        mem[0]     = 16'h60FF;  // JMP 0xFF
        mem[8'hFF] = 16'h0008;  // ADD, then PC wraps to 0x00
        do_reset();
        ack_delay = 3;
        pulse_start();
        wait_fetches(3, "wait");
        n_cmp++; if (wb_cyc.size() !== 1) begin n_mis++; $display("FAIL wait_wr_count: got %0d want 1", wb_cyc.size()); end
        n_cmp++; if (addr_glitch !== 0) begin n_mis++; $display("FAIL wait_addr_stable: got %0d changes want 0", addr_glitch); end
        if (fetch_cyc.size() >= 3 && wb_cyc.size() >= 1) begin
            n_cmp++; if (fetch_wait[0] !== 3) begin n_mis++; $display("FAIL wait_req_hold: got %0d want 3", fetch_wait[0]); end
            n_cmp++; if ({fetch_addr[0], fetch_addr[1], fetch_addr[2]} !== 24'h00FF00) begin n_mis++; $display("FAIL wrap_addrs: got %h want 00ff00", {fetch_addr[0], fetch_addr[1], fetch_addr[2]}); end
            n_cmp++; if (fetch_cyc[1] - fetch_cyc[0] !== 5) begin n_mis++; $display("FAIL jmp_cpi_wait: got %0d want 5", fetch_cyc[1] - fetch_cyc[0]); end
            n_cmp++; if (fetch_cyc[2] - fetch_cyc[1] !== 7) begin n_mis++; $display("FAIL alu_cpi_wait: got %0d want 7", fetch_cyc[2] - fetch_cyc[1]); end
            n_cmp++; if (wb_pc[0] !== 8'hFF) begin n_mis++; $display("FAIL wrap_wb_pc: got %h want ff", wb_pc[0]); end
        end
    endtask

    task automatic test_illegal();
        fill_halts();
        mem[0] = 16'h8000;  // undefined opcode
        mem[1] = 16'hE000;  // NOP
        do_reset();
        n_cmp++; if (illegal_op !== 1'b0) begin n_mis++; $display("FAIL ill_pre: got %b want 0", illegal_op); end
        pulse_start();
        wait_fetches(3, "ill");
        n_cmp++; if (illegal_op !== 1'b1) begin n_mis++; $display("FAIL ill_flag: got %b want 1", illegal_op); end
        n_cmp++; if (wb_cyc.size() !== 0) begin n_mis++; $display("FAIL ill_no_write: got %0d want 0", wb_cyc.size()); end
        if (fetch_cyc.size() >= 3) begin
            n_cmp++; if (fetch_cyc[1] - fetch_cyc[0] !== 2) begin n_mis++; $display("FAIL ill_cpi: got %0d want 2", fetch_cyc[1] - fetch_cyc[0]); end
            n_cmp++; if (fetch_cyc[2] - fetch_cyc[1] !== 2) begin n_mis++; $display("FAIL nop_cpi: got %0d want 2", fetch_cyc[2] - fetch_cyc[1]); end
            n_cmp++; if ({fetch_addr[1], fetch_addr[2]} !== 16'h0102) begin n_mis++; $display("FAIL ill_pc: got %h want 0102", {fetch_addr[1], fetch_addr[2]}); end
        end
        run_cycles(3);
        n_cmp++; if ({halted, busy} !== 2'b10) begin n_mis++; $display("FAIL ill_halt_status: got %b want 10", {halted, busy}); end
        n_cmp++; if (pc_out !== 8'h02) begin n_mis++; $display("FAIL ill_halt_pc: got %h want 02", pc_out); end
        n_cmp++; if (illegal_op !== 1'b1) begin n_mis++; $display("FAIL ill_sticky: got %b want 1", illegal_op); end
    endtask

    task automatic test_halt();
        fill_halts();
        do_reset();
        pulse_start();
        #1;
        n_cmp++; if ({busy, imem_req} !== 2'b11) begin n_mis++; $display("FAIL halt_fetch_status: got %b want 11", {busy, imem_req}); end
        run_cycles(4);
        n_cmp++; if ({halted, busy} !== 2'b10) begin n_mis++; $display("FAIL halt_status: got %b want 10", {halted, busy}); end
        n_cmp++; if (state_dbg !== 3'd5) begin n_mis++; $display("FAIL halt_state: got %0d want 5", state_dbg); end
        pulse_start();
        run_cycles(5);
        n_cmp++; if (fetch_cyc.size() !== 1) begin n_mis++; $display("FAIL halt_start_ignored: got %0d fetches want 1", fetch_cyc.size()); end
        n_cmp++; if ({halted, imem_req, pc_out} !== {1'b1, 1'b0, 8'h00}) begin n_mis++; $display("FAIL halt_frozen: got %h want %h", {halted, imem_req, pc_out}, {1'b1, 1'b0, 8'h00}); end
    endtask

    task automatic test_reset_mid();
        int budget;
        fill_halts();
        mem[0] = 16'h50AA;
        do_reset();
        ack_delay = 10;
        pulse_start();
        run_cycles(2);
        n_cmp++; if (imem_req !== 1'b1) begin n_mis++; $display("FAIL midf_pre_req: got %b want 1", imem_req); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({imem_req, busy, rwe, state_dbg} !== 6'd0) begin n_mis++; $display("FAIL midf_drop: got %b want 000000", {imem_req, busy, rwe, state_dbg}); end
        n_cmp++; if ({pc_out, current_instruction} !== 24'h0) begin n_mis++; $display("FAIL midf_regs: got %h want 000000", {pc_out, current_instruction}); end
        @(negedge clk);
        rst = 1'b1;
        ack_delay = 0;
        #1;
        clear_log();
        // Reset during WRITEBACK: strobe drops at once, nothing further written
        pulse_start();
        budget = 20;
        while (rwe !== 1'b1 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++; if (rwe !== 1'b1) begin n_mis++; $display("FAIL midw_reach: got %b want 1", rwe); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({rwe, ldi, imm} !== 10'h000) begin n_mis++; $display("FAIL midw_drop: got %h want 000", {rwe, ldi, imm}); end
        run_cycles(3);
        n_cmp++; if (wb_cyc.size() !== 1) begin n_mis++; $display("FAIL midw_no_extra: got %0d want 1", wb_cyc.size()); end
        rst = 1'b1;
        run_cycles(1);
    endtask

`ifdef STEP_DEBUG_EN
    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic test_step();
        fill_halts();
        mem[0] = 16'h50AA;
        mem[1] = 16'h520C;
        do_reset();
        pulse_start();
        run_cycles(8);
        n_cmp++; if ({fetch_cyc.size(), wb_cyc.size()} !== {32'd1, 32'd1}) begin n_mis++; $display("FAIL step_park: got %0d/%0d want 1/1", fetch_cyc.size(), wb_cyc.size()); end
        n_cmp++; if ({busy, state_dbg} !== {1'b0, 3'd6}) begin n_mis++; $display("FAIL step_pause: got %b want 0110", {busy, state_dbg}); end
        pulse_step();
        run_cycles(8);
        n_cmp++; if ({fetch_cyc.size(), wb_cyc.size()} !== {32'd2, 32'd2}) begin n_mis++; $display("FAIL step_one: got %0d/%0d want 2/2", fetch_cyc.size(), wb_cyc.size()); end
        pulse_step();
        run_cycles(4);
        n_cmp++; if (halted !== 1'b1) begin n_mis++; $display("FAIL step_halt: got %b want 1", halted); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        fill_halts();
        test_reset();
        test_ldi();
        test_alu();
        test_wait_wrap();
        test_illegal();
        test_halt();
        test_reset_mid();
`ifdef STEP_DEBUG_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Multi-cycle control FSM for the 8-bit RISC datapath. It sequences fetch, decode, execute and writeback around the existing register file and ALU. It owns the program counter and instruction register, and runs a req/ack handshake with instruction memory. It drives the register-select, ALU-op, write-enable and load-immediate controls that the datapath consumes.

## Interface
- PC_WIDTH, 8, program counter / imem address width
- INSTR_WIDTH, 16, instruction width; fixed by the instruction format, other values unsupported
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from the current PC when IDLE
- step  in  1  single-step pulse; present only with STEP_DEBUG_EN
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address, equals PC
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  fetched instruction
- current_instruction  out  16  instruction register (IR)
- program_counter_out  out  PC_WIDTH  PC
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT
- dest_reg_sel, src_reg1_sel, src_reg2_sel  out  3 each  register selects
- immediate_data  out  8  IR[7:0]
- load_immediate  out  1  writeback source is immediate_data, not the ALU
- reg_write_enable  out  1  register-file write strobe
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- illegal_op  out  1  sticky; set on an undefined opcode

## Operation
- Format: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3], imm=IR[7:0].
- Opcodes:
  - 0000..0011: ADD, SUB, AND, OR
  - 0100: NOT rd,rs1; rs2 select forced to 000
  - 0101: LDI rd,imm
  - 0110: JMP imm
  - 1110: NOP
  - 1111: HALT
  - all others: illegal; treated as NOP and set illegal_op
- States and transitions:
  - IDLE: start → FETCH.
  - FETCH: imem_req=1, imem_addr=PC, held until imem_ack. On ack, IR ← imem_rdata → DECODE.
  - DECODE: ALU ops → EXECUTE. LDI → WRITEBACK. JMP: PC ← imm → FETCH. NOP or illegal: PC+1 → FETCH. HALT → HALT, PC unchanged.
  - EXECUTE: selects and alu_op stable; the ALU settles. → WRITEBACK.
  - WRITEBACK: reg_write_enable=1 for exactly one cycle; PC ← PC+1 → FETCH.
  - HALT: terminal until reset; start is ignored.
- Selects, alu_op, immediate_data and load_immediate are decoded from IR and stay stable from DECODE through WRITEBACK.
- load_immediate=1 only for LDI. reg_write_enable=0 in every state except WRITEBACK.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00.

## Timing
- Reset values: PC=0, IR=0, state=IDLE, and every output 0 (alu_op=000, selects=000).
- Minimum FETCH is 1 cycle, when ack arrives in the same cycle as req. Each wait cycle extends FETCH by one.
- Cycles per instruction with zero-wait memory: ALU ops 4, LDI 3, JMP/NOP/illegal 2, HALT 2 then parked.
- Register write lands on the rising edge that ends WRITEBACK; the result is visible in the register file on the next FETCH cycle.
- imem_ack outside FETCH is ignored. start outside IDLE is ignored.
- Reset asserted mid-operation, including mid-FETCH: imem_req and reg_write_enable drop immediately (asynchronously); no partial write occurs.
- illegal_op clears only on reset.

## Configuration
- STEP_DEBUG_EN defined:
  - adds the step input and a PAUSE state;
  - every path that would re-enter FETCH (after WRITEBACK, JMP, NOP, illegal) goes to PAUSE instead;
  - PAUSE → FETCH on a step pulse; busy=0 in PAUSE.
- STEP_DEBUG_EN undefined: no step port, no PAUSE state; execution is continuous.

## Structure
- Package risc_ctrl_pkg:
  - opcode localparams;
  - alu_op encodings (shared with the ALU and decoder);
  - state encoding;
  - instruction field bit positions.
- One sub-module, risc_ctrl_decode: combinational IR → selects, alu_op, load_immediate, is_alu, is_jmp, is_halt, is_illegal. The FSM and PC/IR registers stay in risc_sequencer.

## Test plan
- Reset then start; imem returns LDI r0,0xAA (0x50AA) then LDI r1,0x0C (0x520C), zero-wait → two one-cycle reg_write_enable pulses with load_immediate=1, dest 000 then 001, immediate 0xAA then 0x0C; PC=2 after 6 cycles.
- ADD r0,r0,r1 (0x0008) → 4 cycles; in WRITEBACK alu_op=000, dest=000, src1=000, src2=001, load_immediate=0; PC+1. Repeat for SUB/AND/OR with the same fields and alu_op 001/010/011.
- NOT r0,r0 (0x4000) → alu_op=100, src2=000, 4 cycles.
- imem_ack delayed 3 cycles → imem_req held 4 cycles with imem_addr stable and no write pulse. JMP 0xFF followed by an ALU op → PC wraps 0xFF→0x00.
- Opcode 0x8 → illegal_op=1, no write, PC+1. HALT (0xF000) → halted=1, busy=0, PC frozen, start ignored. Reset mid-FETCH → all outputs 0 immediately.
- STEP_DEBUG_EN: after each instruction the FSM parks in PAUSE with busy=0; each step pulse executes exactly one instruction.
